// File: rtl/lpm_result_stage.sv
// lpm_result_stage
//
// Result stage of the output-port-lookup path. Each AXI4-Stream packet is
// buffered in a small first-word-fall-through FIFO. The stage sends one
// lookup request to an external match engine for each packet header. It
// waits as long as needed for the engine's answer, then resolves the next
// hop and output queue from a flattened LPM table and releases the packet
// unmodified.
//
// CPU-bound packets skip the lookup. Out-of-range match indices count as
// misses. Misses are tallied in a saturating counter.
//
// Ports
//   AXI_ACLK, AXI_RESET       clock, synchronous active-high reset
//   S_AXIS_*                  slave stream in; TREADY drops at FIFO nearly-full
//   M_AXIS_*                  master stream out; beats pass through unchanged
//   lpm_table                 NUM_ENTRIES x 64b; [63:32] output queue, [31:0] next hop
//   ip_addr_in                destination IP of the current header
//   lookup_req                one-cycle request pulse, once per looked-up header
//   lookup_valid/hit/index    match engine result
//   miss_clear                clears miss_count (wins over an increment)
//   lpm_hit, nh_reg, oq_reg   per-packet lookup result, stable while the packet leaves
//   miss_count                saturating miss counter

module lpm_result_stage #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_ENTRIES          = 32,
    parameter int unsigned INDEX_WIDTH          = 5,
    parameter int unsigned DST_PORT_POS         = 24,
    parameter int unsigned FIFO_DEPTH_BITS      = 2
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

    input  logic [NUM_ENTRIES*64-1:0]           lpm_table,
    input  logic [31:0]                         ip_addr_in,
    output logic                                lookup_req,
    input  logic                                lookup_valid,
    input  logic                                lookup_hit,
    input  logic [INDEX_WIDTH-1:0]              lookup_index,
    input  logic                                miss_clear,

    output logic                                lpm_hit,
    output logic [31:0]                         nh_reg,
    output logic [31:0]                         oq_reg,
    output logic [31:0]                         miss_count
);

    localparam int unsigned StrbW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BeatW     = C_S_AXIS_DATA_WIDTH + StrbW + C_S_AXIS_TUSER_WIDTH + 1;
    localparam int unsigned FifoDepth = 1 << FIFO_DEPTH_BITS;

    // One slot is kept in reserve so an upstream beat already in flight can still land.
    localparam logic [FIFO_DEPTH_BITS:0] NearlyFullLvl = (FIFO_DEPTH_BITS + 1)'(FifoDepth - 1);
    localparam logic [INDEX_WIDTH:0]     NumEntriesW   = (INDEX_WIDTH + 1)'(NUM_ENTRIES);

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StHdr,
        StBody
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [BeatW-1:0]           mem_q [FifoDepth];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_BITS:0]   count_q, count_d;

    logic                       fifo_empty;
    logic                       fifo_nearly_full;
    logic                       wr_en;
    logic                       rd_en;

    logic [BeatW-1:0]                   head;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     head_data;
    logic [StrbW-1:0]                   head_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    head_user;
    logic                               head_last;
    logic                               head_cpu;

    logic                       m_tvalid;

    assign fifo_empty       = (count_q == '0);
    assign fifo_nearly_full = (count_q >= NearlyFullLvl);
    assign S_AXIS_TREADY    = !fifo_nearly_full;

    assign wr_en = S_AXIS_TVALID & S_AXIS_TREADY;
    assign rd_en = m_tvalid & M_AXIS_TREADY;

    assign head = mem_q[rd_ptr_q];
    assign {head_last, head_user, head_strb, head_data} = head;

    // The odd bits of the one-hot destination field are the CPU queues.
    assign head_cpu = head_user[DST_PORT_POS + 1] | head_user[DST_PORT_POS + 3] |
                      head_user[DST_PORT_POS + 5] | head_user[DST_PORT_POS + 7];

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge AXI_ACLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = head_cpu ? StHdr : StLookup;
                end
            end
            StLookup: begin
                if (lookup_valid) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (rd_en) begin
                    state_d = head_last ? StIdle : StBody;
                end
            end
            StBody: begin
                if (rd_en && head_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_tvalid   = 1'b0;
        lookup_req = 1'b0;
        unique case (state_q)
            StIdle:        lookup_req = !fifo_empty && !head_cpu;
            StLookup:      m_tvalid   = 1'b0;
            StHdr, StBody: m_tvalid   = !fifo_empty;
            default: begin
                m_tvalid   = 1'b0;
                lookup_req = 1'b0;
            end
        endcase
    end

    // Stream outputs are zeroed while not valid so stale FIFO contents never show.
    assign M_AXIS_TVALID = m_tvalid;
    assign M_AXIS_TDATA  = m_tvalid ? head_data : '0;
    assign M_AXIS_TSTRB  = m_tvalid ? head_strb : '0;
    assign M_AXIS_TUSER  = m_tvalid ? head_user : '0;
    assign M_AXIS_TLAST  = m_tvalid ? head_last : 1'b0;

    // ------------------------------------------------------------------
    // Lookup result registers
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH:0] idx_ext;
    logic                 idx_ok;
    logic [63:0]          sel_entry;

    logic                 hit_q, hit_d;
    logic [31:0]          nh_q, nh_d;
    logic [31:0]          oq_q, oq_d;
    logic [31:0]          miss_q, miss_d;
    logic                 miss_inc;

    assign idx_ext = {1'b0, lookup_index};
    assign idx_ok  = (idx_ext < NumEntriesW);

    // Explicit mux rather than a variable part-select, so an index outside
    // the table simply selects nothing.
    always_comb begin
        sel_entry = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (idx_ext == i[INDEX_WIDTH:0]) begin
                sel_entry = lpm_table[64*i +: 64];
            end
        end
    end

    always_comb begin
        hit_d    = hit_q;
        nh_d     = nh_q;
        oq_d     = oq_q;
        miss_inc = 1'b0;

        if (state_q == StIdle && !fifo_empty && head_cpu) begin
            hit_d = 1'b0;
        end else if (state_q == StLookup && lookup_valid) begin
            if (lookup_hit && idx_ok) begin
                hit_d = 1'b1;
                oq_d  = sel_entry[63:32];
                // A zero next hop marks a directly connected route.
                nh_d  = (sel_entry[31:0] == 32'd0) ? ip_addr_in : sel_entry[31:0];
            end else begin
                hit_d    = 1'b0;
                miss_inc = 1'b1;
            end
        end
    end

    always_comb begin
        miss_d = miss_q;
        if (miss_clear) begin
            miss_d = 32'd0;
        end else if (miss_inc && miss_q != 32'hFFFF_FFFF) begin
            miss_d = miss_q + 32'd1;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            hit_q  <= 1'b0;
            nh_q   <= 32'd0;
            oq_q   <= 32'd0;
            miss_q <= 32'd0;
        end else begin
            hit_q  <= hit_d;
            nh_q   <= nh_d;
            oq_q   <= oq_d;
            miss_q <= miss_d;
        end
    end

    assign lpm_hit    = hit_q;
    assign nh_reg     = nh_q;
    assign oq_reg     = oq_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_lpm_result_stage.sv
// tb_lpm_result_stage
//
// Directed bench for lpm_result_stage. A table of packet records drives
// lookups, bypass and miss cases. Hand sequences cover the reset state,
// back-to-back packets under toggling backpressure, and reset mid-packet.
// A small engine process answers lookup requests from a response queue.
// A negedge monitor captures output beats and request pulses.

module tb_lpm_result_stage;

    localparam int unsigned DataW   = 256;
    localparam int unsigned UserW   = 128;
    localparam int unsigned Entries = 32;
    localparam int unsigned IdxW    = 6;
    localparam int unsigned DstPos  = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic [DataW-1:0]   s_tdata;
    logic [DataW/8-1:0] s_tstrb;
    logic [UserW-1:0]   s_tuser;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;
    logic [DataW-1:0]   m_tdata;
    logic [DataW/8-1:0] m_tstrb;
    logic [UserW-1:0]   m_tuser;
    logic               m_tvalid;
    logic               m_tlast;
    logic               m_tready;
    logic [Entries*64-1:0] tbl;
    logic [31:0]        ip;
    logic               lookup_req;
    logic               lookup_valid;
    logic               lookup_hit;
    logic [IdxW-1:0]    lookup_index;
    logic               miss_clear;
    logic               lpm_hit;
    logic [31:0]        nh_reg;
    logic [31:0]        oq_reg;
    logic [31:0]        miss_count;

    lpm_result_stage #(
        .C_S_AXIS_DATA_WIDTH (DataW),
        .C_S_AXIS_TUSER_WIDTH(UserW),
        .NUM_ENTRIES         (Entries),
        .INDEX_WIDTH         (IdxW),
        .DST_PORT_POS        (DstPos),
        .FIFO_DEPTH_BITS     (2)
    ) dut (
        .AXI_ACLK      (clk),
        .AXI_RESET     (rst),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TSTRB  (s_tstrb),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .lpm_table     (tbl),
        .ip_addr_in    (ip),
        .lookup_req    (lookup_req),
        .lookup_valid  (lookup_valid),
        .lookup_hit    (lookup_hit),
        .lookup_index  (lookup_index),
        .miss_clear    (miss_clear),
        .lpm_hit       (lpm_hit),
        .nh_reg        (nh_reg),
        .oq_reg        (oq_reg),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             hit;
        logic [IdxW-1:0]  idx;
        int               delay;
        logic             clr;
    } resp_t;

    typedef struct {
        logic [DataW-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        logic [DataW-1:0] data;
        logic             last;
        logic             hit;
        logic [31:0]      nh;
        logic [31:0]      oq;
        int               cyc;
    } obs_t;

    typedef struct {
        int              beats;
        logic            cpu;
        logic            hit;
        logic [IdxW-1:0] idx;
        int              delay;
        logic            clr;
        logic [31:0]     ip;
        int              exp_req;
        logic            exp_hit;
        logic [31:0]     exp_nh;
        logic [31:0]     exp_oq;
        logic [31:0]     exp_miss;
        int              exp_lat;
    } vec_t;

    resp_t resp_q[$];
    beat_t exp_q[$];
    obs_t  out_q[$];
    vec_t  vecs[7];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int req_cnt = 0;
    int req_cyc = 0;
    int pid = 1;

    task automatic chk(input string name, input logic [DataW-1:0] act, input logic [DataW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: a handshake seen at the negedge completes at the following posedge.
    initial forever begin
        obs_t o;
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            o.data = m_tdata;
            o.last = m_tlast;
            o.hit  = lpm_hit;
            o.nh   = nh_reg;
            o.oq   = oq_reg;
            o.cyc  = cyc;
            out_q.push_back(o);
        end
        if (lookup_req) begin
            req_cnt++;
            req_cyc = cyc;
        end
    end

    // Match engine: answers each request "delay" cycles later with a one-cycle strobe.
    initial begin
        resp_t r;
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
        lookup_index = '0;
        miss_clear   = 1'b0;
        forever begin
            @(negedge clk);
            if (lookup_req && !rst) begin
                if (resp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL engine_response: actual=none required=queued");
                end else begin
                    r = resp_q.pop_front();
                    repeat (r.delay) @(posedge clk);
                    #1;
                    lookup_valid = 1'b1;
                    lookup_hit   = r.hit;
                    lookup_index = r.idx;
                    miss_clear   = r.clr;
                    @(posedge clk);
                    #1;
                    lookup_valid = 1'b0;
                    lookup_hit   = 1'b0;
                    miss_clear   = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input logic [DataW-1:0] d, input logic [UserW-1:0] u,
                             input logic l);
        int t = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!s_tready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("push_timeout", 1, 0);
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic cpu);
        logic [UserW-1:0] u;
        logic [31:0]      w;
        beat_t            e;
        u = '0;
        if (cpu) u[DstPos + 1] = 1'b1;
        else     u[DstPos]     = 1'b1;
        for (int b = 0; b < n; b++) begin
            w      = {pid[15:0], b[15:0]};
            e.data = {8{w}};
            e.last = (b == n - 1);
            exp_q.push_back(e);
            push_beat(e.data, u, e.last);
        end
        pid++;
    endtask

    task automatic run_pkt(input vec_t v);
        int    req0 = req_cnt;
        int    t = 0;
        int    first_cyc = 0;
        obs_t  o;
        beat_t e;
        resp_t r;
        if (!v.cpu) begin
            r.hit   = v.hit;
            r.idx   = v.idx;
            r.delay = v.delay;
            r.clr   = v.clr;
            resp_q.push_back(r);
        end
        ip = v.ip;
        send_pkt(v.beats, v.cpu);
        while (out_q.size() < v.beats && t < 200) begin
            step();
            t++;
        end
        chk("beats_out", out_q.size(), v.beats);
        for (int b = 0; b < v.beats; b++) begin
            if (out_q.size() > 0 && exp_q.size() > 0) begin
                o = out_q.pop_front();
                e = exp_q.pop_front();
                if (b == 0) first_cyc = o.cyc;
                chk("beat_data", o.data, e.data);
                chk("beat_last", o.last, e.last);
                chk("lpm_hit", o.hit, v.exp_hit);
                chk("nh_reg", o.nh, v.exp_nh);
                chk("oq_reg", o.oq, v.exp_oq);
            end
        end
        chk("lookup_req_count", req_cnt - req0, v.exp_req);
        chk("miss_count", miss_count, v.exp_miss);
        if (v.exp_lat != 0) chk("req_to_header", first_cyc - req_cyc, v.exp_lat);
    endtask

    initial begin
        int    t;
        int    req0;
        obs_t  o;
        beat_t e;
        resp_t r;
        logic [31:0] exp_nh3[3];

        rst      = 1'b1;
        s_tdata  = '0;
        s_tstrb  = '1;
        s_tuser  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        ip       = '0;
        for (int i = 0; i < Entries; i++) begin
            tbl[64*i +: 64] = {32'h100 + 32'(i), 32'h0B00_0000 + 32'(i)};
        end
        tbl[64*7 +: 64] = {32'h2, 32'h0A00_0001};
        tbl[64*3 +: 64] = {32'h5, 32'h0};

        // beats cpu hit idx delay clr ip | req hit nh oq miss latency(0 = skip)
        vecs[0] = '{3, 1'b0, 1'b1, 6'd7,  4, 1'b0, 32'h0101_0101,
                    1, 1'b1, 32'h0A00_0001, 32'h2,   32'd0, 5};
        vecs[1] = '{2, 1'b0, 1'b1, 6'd3,  1, 1'b0, 32'hC0A8_0105,
                    1, 1'b1, 32'hC0A8_0105, 32'h5,   32'd0, 2};
        vecs[2] = '{2, 1'b1, 1'b0, 6'd0,  1, 1'b0, 32'h0,
                    0, 1'b0, 32'hC0A8_0105, 32'h5,   32'd0, 0};
        vecs[3] = '{1, 1'b0, 1'b0, 6'd5,  2, 1'b0, 32'h0,
                    1, 1'b0, 32'hC0A8_0105, 32'h5,   32'd1, 3};
        vecs[4] = '{1, 1'b0, 1'b1, 6'd40, 1, 1'b0, 32'h0,
                    1, 1'b0, 32'hC0A8_0105, 32'h5,   32'd2, 2};
        vecs[5] = '{3, 1'b0, 1'b1, 6'd0,  3, 1'b0, 32'h0,
                    1, 1'b1, 32'h0B00_0000, 32'h100, 32'd2, 4};
        vecs[6] = '{1, 1'b0, 1'b0, 6'd9,  1, 1'b1, 32'h0,
                    1, 1'b0, 32'h0B00_0000, 32'h100, 32'd0, 2};

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_lookup_req", lookup_req, 0);
        chk("reset_lpm_hit", lpm_hit, 0);
        chk("reset_nh_reg", nh_reg, 0);
        chk("reset_oq_reg", oq_reg, 0);
        chk("reset_miss_count", miss_count, 0);
        chk("reset_s_tready", s_tready, 1);

        for (int i = 0; i < 7; i++) begin
            run_pkt(vecs[i]);
            step();
        end

        // Three single-beat packets queued behind a stalled output, then drained
        // with TREADY toggling 1,0,1,0...
        m_tready = 1'b0;
        req0 = req_cnt;
        ip = 32'h0;
        for (int i = 0; i < 3; i++) begin
            r.hit   = 1'b1;
            r.idx   = (i == 2) ? 6'd4 : 6'(i + 1);
            r.delay = 1;
            r.clr   = 1'b0;
            resp_q.push_back(r);
        end
        exp_nh3[0] = 32'h0B00_0001;
        exp_nh3[1] = 32'h0B00_0002;
        exp_nh3[2] = 32'h0B00_0004;
        send_pkt(1, 1'b0);
        send_pkt(1, 1'b0);
        send_pkt(1, 1'b0);
        chk("s_tready_nearly_full", s_tready, 0);
        chk("tvalid_held", m_tvalid, 1);
        t = 0;
        while (out_q.size() < 3 && t < 200) begin
            m_tready = (t % 2 == 0);
            step();
            t++;
        end
        m_tready = 1'b1;
        chk("b2b_beats_out", out_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (out_q.size() > 0 && exp_q.size() > 0) begin
                o = out_q.pop_front();
                e = exp_q.pop_front();
                chk("b2b_data", o.data, e.data);
                chk("b2b_last", o.last, 1);
                chk("b2b_hit", o.hit, 1);
                chk("b2b_nh", o.nh, exp_nh3[i]);
            end
        end
        chk("b2b_req_count", req_cnt - req0, 3);
        step();
        chk("b2b_s_tready", s_tready, 1);

        // Reset while the packet body is still queued.
        r.hit   = 1'b1;
        r.idx   = 6'd7;
        r.delay = 1;
        r.clr   = 1'b0;
        resp_q.push_back(r);
        send_pkt(3, 1'b0);
        t = 0;
        while (out_q.size() < 1 && t < 200) begin
            step();
            t++;
        end
        m_tready = 1'b0;
        chk("pre_reset_nh", nh_reg, 32'h0A00_0001);
        rst = 1'b1;
        step();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_lpm_hit", lpm_hit, 0);
        chk("rst_nh_reg", nh_reg, 0);
        chk("rst_oq_reg", oq_reg, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_fifo_empty_tready", s_tready, 1);
        rst = 1'b0;
        exp_q.delete();
        out_q.delete();
        resp_q.delete();
        m_tready = 1'b1;
        step();
        chk("post_rst_tvalid", m_tvalid, 0);
        run_pkt(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
